// File: rtl/mul16_seq.sv
// mul16_seq: sequential shift-and-add unsigned multiplier.
// One multiplier bit is examined per cycle (LSB first), so each operation
// spends exactly WIDTH cycles in RUN, then holds its result in DONE until
// the consumer takes it.
//
// Ports:
//   clk        sole clock, rising edge
//   reset      synchronous, active-high
//   in_valid   operand pair a/b presented
//   in_ready   block accepts operands this cycle (IDLE only)
//   a, b       unsigned multiplicand / multiplier
//   out_valid  product/overflow hold a completed result (DONE only)
//   out_ready  consumer accepts the result this cycle
//   product    low WIDTH bits of a*b
//   overflow   high WIDTH bits of a*b are nonzero
module mul16_seq #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] product,
  output logic             overflow
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t               state, state_nxt;
  logic [WIDTH-1:0]     a_q, b_q;
  logic [2*WIDTH-1:0]   acc, addend, sum;
  logic [CW-1:0]        cnt;
  logic                 last;
  logic                 carry;

  assign last      = (cnt == CW'(WIDTH - 1));
  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid)  state_nxt = RUN;
      RUN:     if (last)      state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default:                state_nxt = IDLE;
    endcase
  end

  // Partial product for the current multiplier bit, aligned to its weight.
  always_comb begin
    addend = '0;
    if (b_q[cnt]) addend = {{WIDTH{1'b0}}, a_q} << cnt;
  end

  // Full-width ripple-carry adder: accumulator + partial product.
  always_comb begin
    sum   = '0;
    carry = 1'b0;
    for (int i = 0; i < 2*WIDTH; i++) begin
      sum[i] = acc[i] ^ addend[i] ^ carry;
      carry  = (acc[i] & addend[i]) | (carry & (acc[i] ^ addend[i]));
    end
  end

  // Datapath. product/overflow only change on the last RUN cycle, so they
  // keep the last delivered result through DONE and the following IDLE.
  always_ff @(posedge clk) begin
    if (reset) begin
      a_q      <= '0;
      b_q      <= '0;
      acc      <= '0;
      cnt      <= '0;
      product  <= '0;
      overflow <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_q <= a;
            b_q <= b;
            acc <= '0;
            cnt <= '0;
          end
        end
        RUN: begin
          acc <= sum;
          cnt <= last ? '0 : cnt + CW'(1);
          if (last) begin
            product  <= sum[WIDTH-1:0];
            overflow <= |sum[2*WIDTH-1:WIDTH];
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mul16_seq.sv
module tb_mul16_seq;
  localparam int W = 16;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a, b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] product;
  logic         overflow;

  int ncmp = 0;
  int nerr = 0;
  int cyc  = 0;

  logic [W:0] sb_q[$];   // {overflow, product}
  int         acc_t[$];  // sample index of each accept
  logic [W:0] sb_e;

  mul16_seq #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .product(product), .overflow(overflow)
  );

  always #5 clk = ~clk;

  function automatic logic [W:0] model(input logic [W-1:0] x, input logic [W-1:0] y);
    logic [2*W-1:0] full;
    full = {{W{1'b0}}, x} * {{W{1'b0}}, y};
    return {|full[2*W-1:W], full[W-1:0]};
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    ncmp++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Scoreboard monitor: samples mid-cycle, after the drivers have settled
  // and well before the next rising edge.
  always @(negedge clk) begin
    #2;
    cyc++;
    if (reset) begin
      sb_q.delete();
    end else begin
      if (in_valid && in_ready) begin
        sb_q.push_back(model(a, b));
        acc_t.push_back(cyc);
      end
      if (out_valid && out_ready) begin
        if (sb_q.size() == 0) chk("sb_unexpected", 1, 0);
        else begin
          sb_e = sb_q.pop_front();
          chk("sb_prod", product, sb_e[W-1:0]);
          chk("sb_ovf", overflow, sb_e[W]);
        end
      end
    end
  end

  // One operation from IDLE: latency, stall stability, handoff, retention.
  task automatic op(input logic [W-1:0] x, input logic [W-1:0] y,
                    input int stall, input bit tog);
    logic [W:0] e;
    int n;
    e = model(x, y);
    chk("op_in_ready", in_ready, 1);
    a = x; b = y; in_valid = 1'b1; out_ready = (stall == 0);
    @(negedge clk);
    in_valid = 1'b0;
    n = 1;
    while (!out_valid && n < 64) begin
      if (tog) begin a = W'($urandom); b = W'($urandom); end
      @(negedge clk);
      n++;
    end
    chk("latency", n, W + 1);
    chk("prod", product, e[W-1:0]);
    chk("ovf", overflow, e[W]);
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      chk("hold_vld", out_valid, 1);
      chk("hold_prod", product, e[W-1:0]);
      chk("hold_ovf", overflow, e[W]);
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("idle_vld", out_valid, 0);
    chk("idle_rdy", in_ready, 1);
    chk("retain", product, e[W-1:0]);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int cnt_ov;
    reset = 1'b1; in_valid = 1'b1; a = 16'h0005; b = 16'h0005; out_ready = 1'b0;
    repeat (3) @(negedge clk);
    // in_valid held high during reset must not start anything
    chk("rst_rdy", in_ready, 1);
    chk("rst_vld", out_valid, 0);
    chk("rst_prod", product, 0);
    chk("rst_ovf", overflow, 0);
    in_valid = 1'b0; reset = 1'b0;
    @(negedge clk);
    chk("post_rst_rdy", in_ready, 1);
    chk("post_rst_vld", out_valid, 0);

    // directed cases
    op(16'h0003, 16'h0005, 0, 0);
    chk("p_3x5", product, 16'h000F);
    op(16'h0100, 16'h0100, 0, 0);
    chk("p_100sq", product, 16'h0000);
    chk("o_100sq", overflow, 1);
    op(16'hFFFF, 16'hFFFF, 0, 0);
    chk("p_ffffsq", product, 16'h0001);
    chk("o_ffffsq", overflow, 1);
    op(16'h0000, 16'hFFFF, 0, 0);
    chk("p_0", product, 16'h0000);
    chk("o_0", overflow, 0);
    // stalled consumer, operands toggled during RUN
    op(16'h1234, 16'h0002, 10, 1);
    chk("p_1234", product, 16'h2468);

    // reset on the 8th RUN cycle discards the operation
    a = 16'h00FF; b = 16'h0F0F; in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (7) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("rr_rdy", in_ready, 1);
    chk("rr_vld", out_valid, 0);
    chk("rr_prod", product, 0);
    chk("rr_ovf", overflow, 0);
    cnt_ov = 0;
    repeat (20) begin
      @(negedge clk);
      if (out_valid) cnt_ov++;
    end
    chk("rr_no_result", cnt_ov, 0);
    op(16'h0007, 16'h0006, 0, 0);
    chk("p_7x6", product, 16'h002A);

    // back-to-back with in_valid and out_ready held high
    acc_t.delete();
    in_valid = 1'b1; out_ready = 1'b1;
    repeat (3 * (W + 2) + 2) begin
      a = W'($urandom); b = W'($urandom);
      @(negedge clk);
    end
    in_valid = 1'b0;
    repeat (W + 4) @(negedge clk);
    chk("b2b_count", acc_t.size() >= 3, 1);
    for (int i = 0; i + 1 < acc_t.size(); i++)
      chk("b2b_gap", acc_t[i+1] - acc_t[i], W + 2);

    // random run against the reference model
    for (int i = 0; i < 1000; i++)
      op(W'($urandom), W'($urandom),
         ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0,
         bit'($urandom_range(0, 1)));

    @(negedge clk);
    chk("sb_drain", sb_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end
endmodule
